// File: rtl/vm_disp_pkg.sv
// Shared types for the vending-machine dispense controller:
// FSM states, dispense unit codes, slot storage and a slot scanner.
package vm_disp_pkg;

    localparam int NUM_SLOTS = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DISPENSE
    } state_e;

    typedef enum logic [2:0] {
        DT_ITEM = 3'd0,
        DT_50   = 3'd1,
        DT_20   = 3'd2,
        DT_10   = 3'd3,
        DT_5    = 3'd4,
        DT_1    = 3'd5
    } disp_type_e;

    typedef logic [NUM_SLOTS-1:0][3:0] slots_t;
    typedef logic [NUM_SLOTS-1:0][5:0] sold_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Lowest-index nonzero slot; slot index doubles as the disp_type code.
    function automatic pick_t first_nz(input slots_t s);
        pick_t p;
        p = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (s[i] != 4'd0) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/vm_disp_watchdog.sv
// Dispense handshake watchdog: counts consecutive stalled cycles.
// Only built when VM_DISP_TIMEOUT_EN is defined.
`ifdef VM_DISP_TIMEOUT_EN
module vm_disp_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic fire
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = run ? cnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the TIMEOUT_CYC-th consecutive stalled cycle.
    assign fire = run && (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/vm_dispense_ctrl.sv
// Captures the 6-beat VM result burst and drives the dispenser handshake.
// Optional stall watchdog enabled by defining VM_DISP_TIMEOUT_EN.
module vm_dispense_ctrl
  import vm_disp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_result,
  input  logic [5:0] in_num,
  input  logic       disp_ready,
  output logic       disp_valid,
  output logic [2:0] disp_type,
  output logic [2:0] disp_item,
  output logic       busy,
  output logic       done,
  output logic       err_overrun,
  output logic       err_short,
  output logic       err_timeout,
  input  logic [2:0] q_idx,
  output logic [5:0] q_num
);

  state_e     state_q, state_d;
  logic [2:0] beat_q, beat_d;
  slots_t     slot_q, slot_d;
  sold_t      sold_tmp_q, sold_tmp_d;
  sold_t      sold_q, sold_d;
  logic       dv_q, dv_d;
  logic [2:0] dt_q, dt_d;
  logic [2:0] di_q, di_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       short_q, short_d;
  logic       hold_q, hold_d;
  pick_t      pick;

`ifdef VM_DISP_TIMEOUT_EN
  logic tmo_q, tmo_d;
  logic wd_fire;

  vm_disp_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (dv_q && !disp_ready),
    .fire (wd_fire)
  );

  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    slot_d     = slot_q;
    sold_tmp_d = sold_tmp_q;
    sold_d     = sold_q;
    dv_d       = dv_q;
    dt_d       = dt_q;
    di_d       = di_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    short_d    = short_q;
    hold_d     = hold_q && in_valid;
    pick       = '0;
`ifdef VM_DISP_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        dv_d = 1'b0;
        if (in_valid && hold_q) begin
          ovr_d = 1'b1;
        end else if (in_valid) begin
          slot_d[0]     = in_result;
          sold_tmp_d[0] = in_num;
          beat_d        = 3'd1;
          state_d       = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!in_valid) begin
          short_d = 1'b1;
          slot_d  = '0;
          beat_d  = 3'd0;
          state_d = ST_IDLE;
        end else begin
          slot_d[beat_q]     = in_result;
          sold_tmp_d[beat_q] = in_num;
          beat_d             = beat_q + 3'd1;
          if (beat_q == 3'(NUM_SLOTS - 1)) begin
            sold_d = sold_tmp_d;
            beat_d = 3'd0;
            hold_d = 1'b1;
            pick   = first_nz(slot_d);
            if (pick.found) begin
              dv_d    = 1'b1;
              dt_d    = pick.idx;
              di_d    = (pick.idx == 3'(DT_ITEM)) ?
                        slot_d[0][2:0] : 3'd0;
              state_d = ST_DISPENSE;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DISPENSE: begin
        if (in_valid) begin
          ovr_d  = 1'b1;
          hold_d = 1'b1;
        end
        if (dv_q && disp_ready) begin
          if (dt_q == 3'(DT_ITEM)) begin
            slot_d[0] = 4'd0;
          end else if (slot_d[dt_q] != 4'd0) begin
            slot_d[dt_q] = slot_d[dt_q] - 4'd1;
          end
          pick = first_nz(slot_d);
          if (pick.found) begin
            dv_d = 1'b1;
            dt_d = pick.idx;
            di_d = (pick.idx == 3'(DT_ITEM)) ?
                   slot_d[0][2:0] : 3'd0;
          end else begin
            dv_d    = 1'b0;
            dt_d    = 3'd0;
            di_d    = 3'd0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
`ifdef VM_DISP_TIMEOUT_EN
        if (wd_fire) begin
          tmo_d   = 1'b1;
          dv_d    = 1'b0;
          dt_d    = 3'd0;
          di_d    = 3'd0;
          slot_d  = '0;
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= 3'd0;
      slot_q     <= '0;
      sold_tmp_q <= '0;
      sold_q     <= '0;
      dv_q       <= 1'b0;
      dt_q       <= 3'd0;
      di_q       <= 3'd0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      short_q    <= 1'b0;
      hold_q     <= 1'b0;
`ifdef VM_DISP_TIMEOUT_EN
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      slot_q     <= slot_d;
      sold_tmp_q <= sold_tmp_d;
      sold_q     <= sold_d;
      dv_q       <= dv_d;
      dt_q       <= dt_d;
      di_q       <= di_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      short_q    <= short_d;
      hold_q     <= hold_d;
`ifdef VM_DISP_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin
    q_num = 6'd0;
    if (q_idx != 3'd0 && q_idx != 3'd7) begin
      q_num = sold_q[q_idx - 3'd1];
    end
  end

  assign disp_valid  = dv_q;
  assign disp_type   = dt_q;
  assign disp_item   = di_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err_overrun = ovr_q;
  assign err_short   = short_q;

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Directed self-checking bench for vm_dispense_ctrl.
// Define VM_DISP_TIMEOUT_EN to also exercise the watchdog.
module tb_vm_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_result;
  logic [5:0] in_num;
  logic       disp_ready;
  logic       disp_valid;
  logic [2:0] disp_type;
  logic [2:0] disp_item;
  logic       busy;
  logic       done;
  logic       err_overrun;
  logic       err_short;
  logic       err_timeout;
  logic [2:0] q_idx;
  logic [5:0] q_num;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vm_dispense_ctrl #(.TIMEOUT_CYC(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_num     (in_num),
    .disp_ready (disp_ready),
    .disp_valid (disp_valid),
    .disp_type  (disp_type),
    .disp_item  (disp_item),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun),
    .err_short  (err_short),
    .err_timeout(err_timeout),
    .q_idx      (q_idx),
    .q_num      (q_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic [2:0] idx,
                       input logic [5:0] exp);
    q_idx = idx;
    #1;
    chk(tag, 32'(q_num), 32'(exp));
  endtask

  task automatic send_burst(input logic [23:0] r, input logic [35:0] n);
    for (int k = 0; k < 6; k++) begin
      in_valid  = 1'b1;
      in_result = r[23 - 4*k -: 4];
      in_num    = n[35 - 6*k -: 6];
      tick();
    end
    in_valid  = 1'b0;
    in_result = 4'd0;
    in_num    = 6'd0;
  endtask

  initial begin
    logic [2:0] exp_t [6];
    exp_t = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_result  = 4'd0;
    in_num     = 6'd0;
    disp_ready = 1'b0;
    q_idx      = 3'd1;
    tick();
    tick();
    chk("rst_dv", 32'(disp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_errs", 32'({err_overrun, err_short, err_timeout}), 0);
    chk("rst_qnum", 32'(q_num), 0);
    rst_n = 1'b1;
    tick();

    disp_ready = 1'b1;
    send_burst({4'd3, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2},
               {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6});
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_dv%0d", i), 32'(disp_valid), 1);
      chk($sformatf("t1_type%0d", i), 32'(disp_type), 32'(exp_t[i]));
      chk($sformatf("t1_item%0d", i), 32'(disp_item), (i == 0) ? 3 : 0);
      if (i < 5) tick();
    end
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_dv_end", 32'(disp_valid), 0);
    chk("t1_busy_end", 32'(busy), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    for (int i = 1; i <= 6; i++) begin
      chk_q($sformatf("t1_q%0d", i), 3'(i), 6'(i));
    end

    send_burst(24'd0, {6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15});
    chk("t2_done", 32'(done), 1);
    chk("t2_dv", 32'(disp_valid), 0);
    chk("t2_busy", 32'(busy), 0);
    chk_q("t2_q3", 3'd3, 6'd12);
    chk_q("t2_q6", 3'd6, 6'd15);
    chk_q("t2_q0", 3'd0, 6'd0);
    chk_q("t2_q7", 3'd7, 6'd0);
    tick();
    chk("t2_done_pulse", 32'(done), 0);

    disp_ready = 1'b1;
    send_burst({4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}, 36'd0);
    chk("t3_type_item", 32'(disp_type), 0);
    chk("t3_item", 32'(disp_item), 1);
    tick();
    disp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold_dv%0d", i), 32'(disp_valid), 1);
      chk($sformatf("t3_hold_type%0d", i), 32'(disp_type), 1);
      tick();
    end
    disp_ready = 1'b1;
    chk("t3_type_50a", 32'(disp_type), 1);
    tick();
    chk("t3_type_50b", 32'(disp_type), 1);
    chk("t3_dv_50b", 32'(disp_valid), 1);
    tick();
    chk("t3_done", 32'(done), 1);
    chk("t3_dv_end", 32'(disp_valid), 0);
    tick();

    disp_ready = 1'b0;
    send_burst({4'd2, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0},
               {6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25});
    chk("t4_item", 32'(disp_item), 2);
    send_burst({4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3}, {6{6'd33}});
    chk("t4_ovr", 32'(err_overrun), 1);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_type_held", 32'(disp_type), 0);
    chk("t4_item_held", 32'(disp_item), 2);
    disp_ready = 1'b1;
    tick();
    chk("t4_type_50", 32'(disp_type), 1);
    tick();
    chk("t4_type_10", 32'(disp_type), 3);
    tick();
    chk("t4_done", 32'(done), 1);
    chk_q("t4_q1", 3'd1, 6'd20);
    chk_q("t4_q6", 3'd6, 6'd25);
    tick();

    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      in_result = 4'd4;
      in_num    = 6'd50;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t5_short", 32'(err_short), 1);
    chk("t5_busy", 32'(busy), 0);
    tick();
    chk("t5_dv", 32'(disp_valid), 0);
    chk_q("t5_q1", 3'd1, 6'd20);

    disp_ready = 1'b0;
    send_burst({4'd6, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0}, {6{6'd9}});
    chk("rm_dv_pre", 32'(disp_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("rm_dv", 32'(disp_valid), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_errs", 32'({err_overrun, err_short}), 0);
    chk_q("rm_q6", 3'd6, 6'd0);
    rst_n = 1'b1;
    tick();

    in_valid  = 1'b1;
    in_result = 4'd0;
    in_num    = 6'd7;
    for (int k = 0; k < 6; k++) tick();
    chk("b7_done", 32'(done), 1);
    tick();
    chk("b7_ovr", 32'(err_overrun), 1);
    chk("b7_busy", 32'(busy), 0);
    in_valid = 1'b0;
    tick();
    chk("b7_idle", 32'(busy), 0);
    chk_q("b7_q2", 3'd2, 6'd7);

`ifdef VM_DISP_TIMEOUT_EN
    disp_ready = 1'b0;
    send_burst({4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 36'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("t6_dv_pre", 32'(disp_valid), 1);
    chk("t6_tmo_pre", 32'(err_timeout), 0);
    tick();
    chk("t6_tmo", 32'(err_timeout), 1);
    chk("t6_dv", 32'(disp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_nodone", 32'(done), 0);
    tick();
    chk("t6_nodone2", 32'(done), 0);
`else
    chk("tmo_tied", 32'(err_timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
